path_query_arbiter: RTL and testbench

Shares one pathDecode engine among NREQ requesters, such as several robots or planners, each submitting (start node, end node) queries. The block grants requests round-robin and drives the engine's start/end node inputs. It holds them stable for a fixed settle window, samples the 100-bit path word and returns it to the granted requester over a valid/ready handshake. It sits between the requester fabric and the engine; the engine is treated as a path function that is valid SETTLE_CYCLES after its inputs change.

---
 rtl/path_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/path_query_arbiter.sv | 99 +++++++++
 tb/tb_path_query_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/path_pkg.sv
// path_pkg: shared widths, node count default and FSM state encoding for the path query arbiter
package path_pkg;
  localparam int NODE_W = 5;
  localparam int PATH_SLOTS = 20;
  localparam int PATH_W = NODE_W * PATH_SLOTS;
  localparam int NUM_NODES_DEF = 26;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above the pointer
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [2:0]      o_idx,
  output logic            o_any
);
  logic [2*NREQ-1:0] w_dbl;
  logic w_found;
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign o_any = |i_req;
  // scan the rotated request vector so the pointer position is searched first
  always_comb begin
    o_idx = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && w_dbl[i]) begin
        w_found = 1'b1;
        o_idx = 3'((int'(i_ptr) + i) % NREQ);
      end
    end
    o_gnt = w_found ? (NREQ'(1) << o_idx) : '0;
  end
endmodule

// File: rtl/path_query_arbiter.sv
// path_query_arbiter: round-robin sharing of one path engine with a settle window and valid/ready responses
module path_query_arbiter
  import path_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NUM_NODES = NUM_NODES_DEF,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*NODE_W-1:0] req_st,
  input  logic [NREQ*NODE_W-1:0] req_end,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [PATH_W-1:0]      resp_path,
  output logic                   resp_err,
  output logic [NODE_W-1:0]      eng_st_node,
  output logic [NODE_W-1:0]      eng_end_node,
  input  logic [PATH_W-1:0]      eng_path,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic [15:0]            query_cnt
);
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  logic [1:0] r_state;
  logic [2:0] r_ptr, r_gid, w_idx;
  logic [CW-1:0] r_cnt;
  logic [NREQ-1:0] r_gnt, r_resp_valid, w_gnt;
  logic [PATH_W-1:0] r_path;
  logic r_err, w_any, w_ok, w_done;
  logic [NODE_W-1:0] r_st, r_end, w_st, w_end;
  logic [15:0] r_qcnt;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req(req_valid),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  assign w_st = req_st[w_idx*NODE_W +: NODE_W];
  assign w_end = req_end[w_idx*NODE_W +: NODE_W];
  assign w_ok = (32'(w_st) < NUM_NODES) && (32'(w_end) < NUM_NODES);
  // only the granted requester's ready bit can be set in r_resp_valid, so others are masked off
  assign w_done = |(resp_ready & r_resp_valid);
  assign req_ready = (r_state == ST_IDLE) ? w_gnt : '0;
  assign resp_valid = r_resp_valid;
  assign resp_path = r_path;
  assign resp_err = r_err;
  assign eng_st_node = r_st;
  assign eng_end_node = r_end;
  assign busy = r_state != ST_IDLE;
  assign grant_id = r_gid;
  assign query_cnt = r_qcnt;
  // grant, hold engine inputs through the settle window, then hold the response until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr <= '0;
      r_gid <= '0;
      r_cnt <= '0;
      r_gnt <= '0;
      r_resp_valid <= '0;
      r_path <= '0;
      r_err <= 1'b0;
      r_st <= '0;
      r_end <= '0;
      r_qcnt <= '0;
    end else if (r_state == ST_IDLE && w_any) begin
      r_gid <= w_idx;
      r_gnt <= w_gnt;
      r_ptr <= (w_idx == 3'(NREQ - 1)) ? '0 : w_idx + 3'd1;
      if (w_ok) begin
        r_st <= w_st;
        r_end <= w_end;
        r_cnt <= CW'(SETTLE_CYCLES - 1);
        r_state <= ST_SETTLE;
      end else begin
        r_path <= '0;
        r_err <= 1'b1;
        r_resp_valid <= w_gnt;
        r_state <= ST_RESPOND;
      end
    end else if (r_state == ST_SETTLE) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      else begin
        r_path <= eng_path;
        r_err <= 1'b0;
        r_resp_valid <= r_gnt;
        r_state <= ST_RESPOND;
      end
    end else if (r_state == ST_RESPOND && w_done) begin
      r_resp_valid <= '0;
      r_qcnt <= r_qcnt + 16'd1;
      r_state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_path_query_arbiter.sv
// tb_path_query_arbiter: randomized queries checked against a transaction-level round-robin model
module tb_path_query_arbiter;
  localparam int N = 4;
  localparam int S = 4;
  localparam int NN = 26;
  localparam int NW = 5;
  localparam int PW = 100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [N*NW-1:0] req_st = '0, req_end = '0;
  logic [PW-1:0] resp_path, eng_path = '0;
  logic resp_err, busy;
  logic [NW-1:0] eng_st_node, eng_end_node;
  logic [2:0] grant_id;
  logic [15:0] query_cnt;
  int n_chk = 0, n_fail = 0;
  int m_ptr = 0, m_cnt = 0, m_st = 0, m_end = 0;
  always #5 clk = ~clk;
  path_query_arbiter #(.NREQ(N), .NUM_NODES(NN), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_st(req_st), .req_end(req_end), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_path(resp_path), .resp_err(resp_err), .eng_st_node(eng_st_node),
    .eng_end_node(eng_end_node), .eng_path(eng_path), .busy(busy),
    .grant_id(grant_id), .query_cnt(query_cnt)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [PW-1:0] rnd_path();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction
  function automatic logic [N*NW-1:0] rnd_nodes(input int mx);
    logic [N*NW-1:0] r;
    for (int k = 0; k < N; k++) r[k*NW +: NW] = NW'($urandom_range(0, mx));
    return r;
  endfunction
  function automatic int pick(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return 0;
  endfunction
  task automatic query(input logic [N-1:0] v, input logic [N*NW-1:0] st, input logic [N*NW-1:0] en,
                       input int hold, input logic [PW-1:0] x);
    int g, sg, eg;
    logic ok;
    logic [N-1:0] oh;
    g = pick(v);
    oh = '0;
    oh[g] = 1'b1;
    sg = int'(st[g*NW +: NW]);
    eg = int'(en[g*NW +: NW]);
    ok = (sg < NN) && (eg < NN);
    @(negedge clk);
    req_valid = v;
    req_st = st;
    req_end = en;
    #1;
    check("req_ready", 128'(req_ready), 128'(oh));
    check("idle_busy", 128'(busy), 128'(0));
    @(negedge clk);
    m_ptr = (g + 1) % N;
    if (ok) begin
      m_st = sg;
      m_end = eg;
    end
    req_valid = N'($urandom);
    req_st = 20'($urandom);
    req_end = 20'($urandom);
    #1;
    check("grant_id", 128'(grant_id), 128'(g));
    check("busy", 128'(busy), 128'(1));
    check("eng_st", 128'(eng_st_node), 128'(m_st));
    check("eng_end", 128'(eng_end_node), 128'(m_end));
    if (ok) begin
      for (int i = 0; i < S; i++) begin
        if (i > 0) @(negedge clk);
        eng_path = (i == S - 1) ? x : rnd_path();
        #1;
        check("settle_quiet", 128'(resp_valid), 128'(0));
      end
      @(negedge clk);
      #1;
    end
    check("resp_valid", 128'(resp_valid), 128'(oh));
    check("resp_path", 128'(resp_path), ok ? 128'(x) : 128'(0));
    check("resp_err", 128'(resp_err), 128'(!ok));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      resp_ready = N'($urandom) & ~oh;
      req_valid = N'($urandom);
      eng_path = rnd_path();
      #1;
      check("hold_valid", 128'(resp_valid), 128'(oh));
      check("hold_path", 128'(resp_path), ok ? 128'(x) : 128'(0));
      check("hold_ready", 128'(req_ready), 128'(0));
      check("hold_busy", 128'(busy), 128'(1));
    end
    @(negedge clk);
    resp_ready = N'($urandom) | oh;
    #1;
    check("accept_valid", 128'(resp_valid), 128'(oh));
    @(negedge clk);
    resp_ready = '0;
    req_valid = '0;
    m_cnt = (m_cnt + 1) % 65536;
    #1;
    check("done_valid", 128'(resp_valid), 128'(0));
    check("done_busy", 128'(busy), 128'(0));
    check("query_cnt", 128'(query_cnt), 128'(m_cnt));
  endtask
  initial begin
    logic [N*NW-1:0] st, en;
    eng_path = rnd_path();
    repeat (2) @(negedge clk);
    #1;
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_path", 128'(resp_path), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_cnt", 128'(query_cnt), 128'(0));
    check("rst_eng", 128'({eng_st_node, eng_end_node, grant_id, resp_err}), 128'(0));
    rst = 1'b0;
    st = '0;
    en = 20'(25);
    query(4'b0001, st, en, 0, 100'h0_1234_5678_9abc_def0_1234_5678);
    for (int i = 0; i < 5; i++) query(4'hF, rnd_nodes(25), rnd_nodes(25), 0, rnd_path());
    st = rnd_nodes(25);
    st[2*NW +: NW] = 5'd26;
    query(4'b0100, st, rnd_nodes(25), 1, rnd_path());
    query(4'b0010, rnd_nodes(25), rnd_nodes(25), 10, rnd_path());
    for (int i = 0; i < 40; i++)
      query(N'($urandom_range(1, 15)), rnd_nodes(28), rnd_nodes(28), $urandom_range(0, 3), rnd_path());
    @(negedge clk);
    req_valid = 4'b0001;
    req_st = rnd_nodes(25);
    req_end = rnd_nodes(25);
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(resp_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_cnt", 128'(query_cnt), 128'(0));
    check("mid_rst_eng", 128'({eng_st_node, eng_end_node, grant_id}), 128'(0));
    check("mid_rst_path", 128'({resp_path, resp_err}), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    m_st = 0;
    m_end = 0;
    query(4'b0011, rnd_nodes(25), rnd_nodes(25), 0, rnd_path());
    query(4'b0010, rnd_nodes(25), rnd_nodes(25), 2, rnd_path());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
